cp0_coproc: RTL and testbench
=============================

Name: cp0_coproc

Overview:
- Coprocessor-0 for the P7 pipeline, located in the M stage.
- Holds SR, Cause, EPC and PRId; executes mtc0/mfc0/eret.
- Arbitrates hardware interrupts and precise exceptions and raises the request that redirects the PC to the handler and squashes the M/W pipeline register.
- Feeds CP0Out and Req to the M->W register; EPC feeds NPC for eret.

Parameters:
- PRID_VALUE, 32'h2023_0007, read-only processor ID returned for register 15.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  reset, synchronous, active-high.
- i_en  in  1  mtc0 write enable (M-stage instr is mtc0).
- i_CP0Add  in  5  mfc0/mtc0 register number (rd field).
- i_CP0In  in  32  mtc0 write data (forwarded rt).
- i_VPC  in  32  PC of the M-stage instruction (or of the bubble's owner).
- i_BDIn  in  1  M-stage instruction is in a branch delay slot.
- i_ExcCodeIn  in  5  merged exception code from F/D/E/M, 0 = none.
- i_HWInt  in  6  external interrupt lines [5:0] (timer0, timer1, interrupt generator, others 0).
- i_EXLClr  in  1  eret in M stage.
- o_CP0Out  out  32  mfc0 read data.
- o_EPCOut  out  32  EPC for eret target, with mtc0 bypass.
- o_Req  out  1  take exception/interrupt this cycle.

Behaviour:
- Register fields; all other bits read 0 and ignore writes:
  - SR(12): IM[15:10], EXL[1], IE[0].
  - Cause(13): BD[31], IP[15:10], ExcCode[6:2].
  - EPC(14): [31:0].
  - PRId(15): PRID_VALUE.
- Reset: SR, Cause and EPC = 0. o_Req = 0 while i_reset is high. o_CP0Out and o_EPCOut follow the reset register values (0, PRId excepted).
- IntReq = IE & ~EXL & |(i_HWInt & IM). ExcReq = ~EXL & (i_ExcCodeIn != 0). o_Req = (IntReq | ExcReq) & ~i_reset. Purely combinational, same cycle.
- Priority: interrupt over exception. Req over eret and over mtc0 in the same cycle; the squashed mtc0 and eret have no effect.
- On posedge with o_Req:
  - EXL <= 1.
  - BD <= i_BDIn.
  - ExcCode <= IntReq ? 0 : i_ExcCodeIn.
  - EPC <= i_BDIn ? {i_VPC[31:2],2'b00} - 4 : {i_VPC[31:2],2'b00}.
- Else on posedge:
  - i_EXLClr: EXL <= 0.
  - i_en with i_CP0Add = 12: IM, EXL and IE <= i_CP0In fields.
  - i_en with i_CP0Add = 14: EPC <= {i_CP0In[31:2],2'b00}.
  - Writes to 13, 15 or any other address are ignored.
  - If i_EXLClr and an mtc0 to SR occur together, the SR write wins for EXL.
- Cause.IP <= i_HWInt every cycle regardless of Req or EXL (except during reset).
- o_CP0Out: register selected by i_CP0Add; unimplemented addresses read 0. Reads return pre-write values (no same-cycle bypass).
- o_EPCOut = (i_en & i_CP0Add = 14) ? {i_CP0In[31:2],2'b00} : EPC. This covers a back-to-back mtc0 EPC followed by eret.
- While EXL = 1, no further Req is raised (no nesting).
- A Req in the reset cycle is discarded; reset wins.
- EPC subtraction wraps modulo 2^32; 0x0000_0000 with BD gives 0xFFFF_FFFC.

Decomposition:
- def.v additions: CP0 register numbers (SR 12, CAUSE 13, EPC 14, PRID 15), field bit positions, ExcCode constants (Int 0, AdEL 4, AdES 5, RI 10, Ov 12), handler entry NPC_INT 32'h0000_4180.
- Single module; no sub-module needed.

Test Plan:
- mtc0 SR = 32'h0000_FC01 then mfc0 12 -> returns 32'h0000_FC01 (IM = 6'h3F, IE = 1). mtc0 13 with 32'hFFFF_FFFF -> Cause unchanged.
- IE = 1, IM bit 2 set, i_HWInt = 6'b000100, i_VPC = 32'h0000_3010, BD = 0:
  - o_Req = 1 same cycle.
  - Next cycle: EPC = 32'h0000_3010, ExcCode = 0, EXL = 1, Cause.IP = 6'b000100, o_Req = 0 while the line stays high.
- i_ExcCodeIn = 10 (RI), i_BDIn = 1, i_VPC = 32'h0000_3024, IE = 0:
  - o_Req = 1.
  - Next: EPC = 32'h0000_3020, BD = 1, ExcCode = 10.
- Simultaneous interrupt and i_ExcCodeIn = 12 -> ExcCode = 0. A simultaneous mtc0 EPC = 32'h1234_5678 is ignored; EPC = the i_VPC value.
- EXL = 1, i_EXLClr = 1 -> EXL = 0 next cycle.
  - i_en = 1, i_CP0Add = 14, i_CP0In = 32'h0000_4000 -> o_EPCOut = 32'h0000_4000 the same cycle.
- Exception pending with i_reset high -> o_Req = 0, and SR, Cause and EPC read 0 afterwards.

Source files
------------

// File: rtl/cp0_coproc_pkg.sv
// -----------------------------------------------------------------------------
// cp0_coproc_pkg
// Shared definitions for the P7 coprocessor-0: CP0 register numbers, field bit
// positions inside SR and Cause, exception codes, the handler entry address and
// a small word-alignment helper.
// -----------------------------------------------------------------------------
package cp0_coproc_pkg;

    // CP0 register numbers (rd field of mfc0/mtc0)
    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    // SR field positions
    localparam int SR_IE    = 0;
    localparam int SR_EXL   = 1;
    localparam int SR_IM_LO = 10;
    localparam int SR_IM_HI = 15;

    // Cause field positions
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_BD     = 31;

    // ExcCode values
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Handler entry point used by the NPC logic when o_Req is taken
    localparam logic [31:0] NPC_INT = 32'h0000_4180;

    // Clear the two byte-offset bits of an address
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/cp0_coproc.sv
// -----------------------------------------------------------------------------
// cp0_coproc
// Coprocessor-0 of the P7 pipeline, sitting in the M stage. Holds SR, Cause,
// EPC and PRId, executes mtc0/mfc0/eret, and arbitrates hardware interrupts
// against precise exceptions. o_Req redirects the PC to the handler and
// squashes the M/W register in the same cycle.
//
// Ports
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_en             mtc0 in M stage (write enable)
//   i_CP0Add[4:0]    CP0 register number for mfc0/mtc0
//   i_CP0In[31:0]    mtc0 write data
//   i_VPC[31:0]      PC of the M-stage instruction
//   i_BDIn           M-stage instruction is in a branch delay slot
//   i_ExcCodeIn[4:0] merged exception code, 0 = none
//   i_HWInt[5:0]     external interrupt lines
//   i_EXLClr         eret in M stage
//   o_CP0Out[31:0]   mfc0 read data (pre-write value)
//   o_EPCOut[31:0]   eret target, bypassing a same-cycle mtc0 to EPC
//   o_Req            take interrupt/exception this cycle
// -----------------------------------------------------------------------------
module cp0_coproc
    import cp0_coproc_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE = 32'h2023_0007
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_en,
    input  logic [4:0]  i_CP0Add,
    input  logic [31:0] i_CP0In,
    input  logic [31:0] i_VPC,
    input  logic        i_BDIn,
    input  logic [4:0]  i_ExcCodeIn,
    input  logic [5:0]  i_HWInt,
    input  logic        i_EXLClr,
    output logic [31:0] o_CP0Out,
    output logic [31:0] o_EPCOut,
    output logic        o_Req
);

    // Architectural state, only the implemented fields
    logic [5:0]  im_q,  im_d;
    logic        exl_q, exl_d;
    logic        ie_q,  ie_d;
    logic        bd_q,  bd_d;
    logic [5:0]  ip_q,  ip_d;
    logic [4:0]  exc_q, exc_d;
    logic [31:0] epc_q, epc_d;

    logic        int_req;
    logic        exc_req;
    logic        wr_sr;
    logic        wr_epc;
    logic [31:0] vpc_aligned;
    logic [31:0] sr_rd;
    logic [31:0] cause_rd;

    // EXL masks both sources, so an active handler is never re-entered
    assign int_req = ie_q & ~exl_q & (|(i_HWInt & im_q));
    assign exc_req = ~exl_q & (i_ExcCodeIn != 5'd0);
    assign o_Req   = (int_req | exc_req) & ~i_reset;

    assign wr_sr       = i_en & (i_CP0Add == CP0_SR);
    assign wr_epc      = i_en & (i_CP0Add == CP0_EPC);
    assign vpc_aligned = word_align(i_VPC);

    // Next-state: a taken request squashes any mtc0/eret in M
    always_comb begin
        // NOTE: every next-state variable gets a default first so no latch is inferred.
        im_d  = im_q;
        exl_d = exl_q;
        ie_d  = ie_q;
        bd_d  = bd_q;
        exc_d = exc_q;
        epc_d = epc_q;
        ip_d  = i_HWInt;    // interrupt pending bits sample the lines every cycle

        if (o_Req) begin
            exl_d = 1'b1;
            bd_d  = i_BDIn;
            exc_d = int_req ? EXC_INT : i_ExcCodeIn;
            // A delay-slot fault restarts at the branch, one word back (wraps)
            epc_d = i_BDIn ? vpc_aligned - 32'd4 : vpc_aligned;
        end else begin
            if (i_EXLClr) begin
                exl_d = 1'b0;
            end
            // Placed after eret so an mtc0 to SR wins the EXL bit
            if (wr_sr) begin
                im_d  = i_CP0In[SR_IM_HI:SR_IM_LO];
                exl_d = i_CP0In[SR_EXL];
                ie_d  = i_CP0In[SR_IE];
            end
            if (wr_epc) begin
                epc_d = word_align(i_CP0In);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignments so all update together at the edge.
        if (i_reset) begin
            im_q  <= '0;
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
            bd_q  <= 1'b0;
            ip_q  <= '0;
            exc_q <= '0;
            epc_q <= '0;
        end else begin
            im_q  <= im_d;
            exl_q <= exl_d;
            ie_q  <= ie_d;
            bd_q  <= bd_d;
            ip_q  <= ip_d;
            exc_q <= exc_d;
            epc_q <= epc_d;
        end
    end

    // Register images with unimplemented bits forced to zero
    always_comb begin
        sr_rd                           = '0;
        sr_rd[SR_IM_HI:SR_IM_LO]        = im_q;
        sr_rd[SR_EXL]                   = exl_q;
        sr_rd[SR_IE]                    = ie_q;

        cause_rd                        = '0;
        cause_rd[CAUSE_BD]              = bd_q;
        cause_rd[CAUSE_IP_HI:CAUSE_IP_LO]   = ip_q;
        cause_rd[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc_q;
    end

    // mfc0 returns the stored value, never the data being written this cycle
    always_comb begin
        o_CP0Out = '0;
        case (i_CP0Add)
            CP0_SR:    o_CP0Out = sr_rd;
            CP0_CAUSE: o_CP0Out = cause_rd;
            CP0_EPC:   o_CP0Out = epc_q;
            CP0_PRID:  o_CP0Out = PRID_VALUE;
            default:   o_CP0Out = '0;
        endcase
    end

    // Bypass lets an eret directly behind an mtc0 EPC jump to the new target
    assign o_EPCOut = wr_epc ? word_align(i_CP0In) : epc_q;

endmodule

// File: tb/tb_cp0_coproc.sv
// -----------------------------------------------------------------------------
// tb_cp0_coproc
// Directed, table-driven bench for cp0_coproc. Each table row gives the inputs
// for one cycle plus the expected combinational outputs for that cycle; rows
// run back to back so the register state carries from one row to the next.
// A few hand-written sequences follow for multi-cycle corner cases.
// -----------------------------------------------------------------------------
module tb_cp0_coproc;

    localparam logic [31:0] PRID = 32'h2023_0007;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_en;
    logic [4:0]  i_CP0Add;
    logic [31:0] i_CP0In;
    logic [31:0] i_VPC;
    logic        i_BDIn;
    logic [4:0]  i_ExcCodeIn;
    logic [5:0]  i_HWInt;
    logic        i_EXLClr;
    logic [31:0] o_CP0Out;
    logic [31:0] o_EPCOut;
    logic        o_Req;

    cp0_coproc #(.PRID_VALUE(PRID)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_en        (i_en),
        .i_CP0Add    (i_CP0Add),
        .i_CP0In     (i_CP0In),
        .i_VPC       (i_VPC),
        .i_BDIn      (i_BDIn),
        .i_ExcCodeIn (i_ExcCodeIn),
        .i_HWInt     (i_HWInt),
        .i_EXLClr    (i_EXLClr),
        .o_CP0Out    (o_CP0Out),
        .o_EPCOut    (o_EPCOut),
        .o_Req       (o_Req)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic [4:0]  add;
        logic [31:0] cin;
        logic [31:0] vpc;
        logic        bd;
        logic [4:0]  exc;
        logic [5:0]  hw;
        logic        clr;
        logic        e_req;
        logic [31:0] e_out;
        logic [31:0] e_epc;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic rst, input logic en, input logic [4:0] add, input logic [31:0] cin,
        input logic [31:0] vpc, input logic bd, input logic [4:0] exc, input logic [5:0] hw,
        input logic clr, input logic e_req, input logic [31:0] e_out, input logic [31:0] e_epc);
        vec_t v;
        v.rst = rst; v.en = en; v.add = add; v.cin = cin; v.vpc = vpc; v.bd = bd;
        v.exc = exc; v.hw = hw; v.clr = clr; v.e_req = e_req; v.e_out = e_out; v.e_epc = e_epc;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        i_reset     = v.rst;
        i_en        = v.en;
        i_CP0Add    = v.add;
        i_CP0In     = v.cin;
        i_VPC       = v.vpc;
        i_BDIn      = v.bd;
        i_ExcCodeIn = v.exc;
        i_HWInt     = v.hw;
        i_EXLClr    = v.clr;
    endtask

    // Drive one cycle at the falling edge, check outputs 1 ns later
    task automatic step(input string tag, input vec_t v);
        @(negedge i_clk);
        drive(v);
        #1;
        check({tag, ".req"}, {31'd0, o_Req}, {31'd0, v.e_req});
        check({tag, ".cp0out"}, o_CP0Out, v.e_out);
        check({tag, ".epcout"}, o_EPCOut, v.e_epc);
    endtask

    initial begin
        // Power-on reset
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge i_clk);

        //            rst en add  cin            vpc            bd exc hw      clr req out            epcout
        // Reset values and PRId
        vecs.push_back(mk(0, 0, 12, 32'h0,         32'h0,         0, 0,  6'h00, 0, 0, 32'h0,         32'h0));
        vecs.push_back(mk(0, 0, 15, 32'h0,         32'h0,         0, 0,  6'h00, 0, 0, PRID,          32'h0));
        // mtc0 SR (read shows pre-write value), then read back
        vecs.push_back(mk(0, 1, 12, 32'h0000_FC01, 32'h0,         0, 0,  6'h00, 0, 0, 32'h0,         32'h0));
        vecs.push_back(mk(0, 0, 12, 32'h0,         32'h0,         0, 0,  6'h00, 0, 0, 32'h0000_FC01, 32'h0));
        // mtc0 Cause is ignored
        vecs.push_back(mk(0, 1, 13, 32'hFFFF_FFFF, 32'h0,         0, 0,  6'h00, 0, 0, 32'h0,         32'h0));
        vecs.push_back(mk(0, 0, 13, 32'h0,         32'h0,         0, 0,  6'h00, 0, 0, 32'h0,         32'h0));
        // Interrupt on line 2, not in delay slot
        vecs.push_back(mk(0, 0, 14, 32'h0,         32'h0000_3010, 0, 0,  6'h04, 0, 1, 32'h0,         32'h0));
        vecs.push_back(mk(0, 0, 13, 32'h0,         32'h0,         0, 0,  6'h04, 0, 0, 32'h0000_1000, 32'h0000_3010));
        vecs.push_back(mk(0, 0, 14, 32'h0,         32'h0,         0, 0,  6'h04, 0, 0, 32'h0000_3010, 32'h0000_3010));
        vecs.push_back(mk(0, 0, 12, 32'h0,         32'h0,         0, 0,  6'h04, 0, 0, 32'h0000_FC03, 32'h0000_3010));
        // eret clears EXL
        vecs.push_back(mk(0, 0, 12, 32'h0,         32'h0,         0, 0,  6'h00, 1, 0, 32'h0000_FC03, 32'h0000_3010));
        vecs.push_back(mk(0, 0, 12, 32'h0,         32'h0,         0, 0,  6'h00, 0, 0, 32'h0000_FC01, 32'h0000_3010));
        // IE off, then RI exception in a delay slot
        vecs.push_back(mk(0, 1, 12, 32'h0000_FC00, 32'h0,         0, 0,  6'h00, 0, 0, 32'h0000_FC01, 32'h0000_3010));
        vecs.push_back(mk(0, 0, 13, 32'h0,         32'h0000_3024, 1, 10, 6'h00, 0, 1, 32'h0,         32'h0000_3010));
        vecs.push_back(mk(0, 0, 13, 32'h0,         32'h0,         0, 0,  6'h00, 0, 0, 32'h8000_0028, 32'h0000_3020));
        vecs.push_back(mk(0, 0, 14, 32'h0,         32'h0,         0, 0,  6'h00, 0, 0, 32'h0000_3020, 32'h0000_3020));
        // eret together with mtc0 EPC: bypass to o_EPCOut, low bits dropped
        vecs.push_back(mk(0, 1, 14, 32'h0000_4003, 32'h0,         0, 0,  6'h00, 1, 0, 32'h0000_3020, 32'h0000_4000));
        vecs.push_back(mk(0, 0, 12, 32'h0,         32'h0,         0, 0,  6'h00, 0, 0, 32'h0000_FC00, 32'h0000_4000));
        // IE on, then interrupt + Ov + mtc0 EPC in the same cycle
        vecs.push_back(mk(0, 1, 12, 32'h0000_FC01, 32'h0,         0, 0,  6'h00, 0, 0, 32'h0000_FC00, 32'h0000_4000));
        vecs.push_back(mk(0, 1, 14, 32'h1234_5678, 32'h0000_3040, 0, 12, 6'h01, 0, 1, 32'h0000_4000, 32'h1234_5678));
        vecs.push_back(mk(0, 0, 13, 32'h0,         32'h0,         0, 0,  6'h01, 0, 0, 32'h0000_0400, 32'h0000_3040));
        vecs.push_back(mk(0, 0, 14, 32'h0,         32'h0,         0, 0,  6'h01, 0, 0, 32'h0000_3040, 32'h0000_3040));
        // eret with mtc0 SR keeping EXL=1: the SR write wins
        vecs.push_back(mk(0, 1, 12, 32'h0000_FC03, 32'h0,         0, 0,  6'h00, 1, 0, 32'h0000_FC03, 32'h0000_3040));
        vecs.push_back(mk(0, 0, 12, 32'h0,         32'h0,         0, 0,  6'h00, 0, 0, 32'h0000_FC03, 32'h0000_3040));
        vecs.push_back(mk(0, 0, 12, 32'h0,         32'h0,         0, 0,  6'h00, 1, 0, 32'h0000_FC03, 32'h0000_3040));
        // AdEL in a delay slot at address 0: EPC wraps to FFFF_FFFC
        vecs.push_back(mk(0, 0, 14, 32'h0,         32'h0000_0002, 1, 4,  6'h00, 0, 1, 32'h0000_3040, 32'h0000_3040));
        vecs.push_back(mk(0, 0, 14, 32'h0,         32'h0,         0, 0,  6'h00, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC));
        vecs.push_back(mk(0, 0, 13, 32'h0,         32'h0,         0, 0,  6'h00, 0, 0, 32'h8000_0010, 32'hFFFF_FFFC));
        // Clear EXL, then a pending exception during reset is discarded
        vecs.push_back(mk(0, 0, 12, 32'h0,         32'h0,         0, 0,  6'h00, 1, 0, 32'h0000_FC03, 32'hFFFF_FFFC));
        vecs.push_back(mk(1, 0, 14, 32'h0,         32'h0000_5000, 0, 5,  6'h01, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC));
        vecs.push_back(mk(0, 0, 12, 32'h0,         32'h0,         0, 0,  6'h00, 0, 0, 32'h0,         32'h0));
        vecs.push_back(mk(0, 0, 13, 32'h0,         32'h0,         0, 0,  6'h00, 0, 0, 32'h0,         32'h0));
        vecs.push_back(mk(0, 0, 14, 32'h0,         32'h0,         0, 0,  6'h00, 0, 0, 32'h0,         32'h0));

        foreach (vecs[i]) begin
            step($sformatf("vec%0d", i), vecs[i]);
        end

        // Sequence: mtc0 to PRId and to an unimplemented register are ignored
        step("prid_wr",   mk(0, 1, 15, 32'h0000_0000, 32'h0, 0, 0, 6'h00, 0, 0, PRID,  32'h0));
        step("prid_rd",   mk(0, 0, 15, 32'h0,         32'h0, 0, 0, 6'h00, 0, 0, PRID,  32'h0));
        step("r3_wr",     mk(0, 1, 3,  32'hDEAD_BEEF, 32'h0, 0, 0, 6'h00, 0, 0, 32'h0, 32'h0));
        step("r3_rd",     mk(0, 0, 3,  32'h0,         32'h0, 0, 0, 6'h00, 0, 0, 32'h0, 32'h0));

        // Sequence: interrupt line held high after being taken raises no further Req
        step("int_en",    mk(0, 1, 12, 32'h0000_8001, 32'h0, 0, 0, 6'h00, 0, 0, 32'h0, 32'h0));
        step("int_take",  mk(0, 0, 14, 32'h0, 32'h0000_7778, 0, 0, 6'h20, 0, 1, 32'h0, 32'h0));
        for (int k = 0; k < 3; k++) begin
            step($sformatf("int_hold%0d", k),
                 mk(0, 0, 14, 32'h0, 32'h0000_9000, 0, 3'd0, 6'h20, 0, 0, 32'h0000_7778, 32'h0000_7778));
        end
        step("int_cause", mk(0, 0, 13, 32'h0, 32'h0, 0, 0, 6'h20, 0, 0, 32'h0000_8000, 32'h0000_7778));
        step("int_sr",    mk(0, 0, 12, 32'h0, 32'h0, 0, 0, 6'h20, 0, 0, 32'h0000_8003, 32'h0000_7778));

        // Sequence: masked line (IM bit clear) does not interrupt
        step("int_clr",   mk(0, 0, 12, 32'h0, 32'h0, 0, 0, 6'h00, 1, 0, 32'h0000_8003, 32'h0000_7778));
        step("int_mask",  mk(0, 0, 12, 32'h0, 32'h0, 0, 0, 6'h1F, 0, 0, 32'h0000_8001, 32'h0000_7778));

        @(negedge i_clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
